// File: rtl/nabp_pkg.sv
// ============================================================================
// nabp_pkg -- types and constants shared by the NABP shifter and mapper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nabp_pkg;

  // Default projection-line index width; 9 bits covers lines of up to 511 shifts.
  localparam int unsigned C_LEN_W = 9;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_KICK  = 2'd1,
    SH_SHIFT = 2'd2,
    SH_DONE  = 2'd3
  } shifter_state_e;

endpackage

`default_nettype wire

// File: rtl/nabp_shifter.sv
// ============================================================================
// nabp_shifter -- runs one line pass: kick pulse, LEN shift cycles, done pulse.
// Optional macro NABP_SHIFTER_STALL_EN lets pe_stall hold off shifting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nabp_shifter
  import nabp_pkg::*;
#(
  parameter int unsigned LEN_W = C_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sc_fire,
  input  logic [LEN_W-1:0] sc_len,
  input  logic             pe_stall,
  output logic             sc_ready,
  output logic             sh_kick,
  output logic             sh_shift_en,
  output logic             sh_done,
  output logic [LEN_W-1:0] sh_pos
);

  shifter_state_e   r_state;
  shifter_state_e   w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_pos;
  logic             w_accept;
  logic             w_shift_en;
  logic             w_last_shift;

  assign w_accept = (r_state == SH_IDLE) && sc_fire;

`ifdef NABP_SHIFTER_STALL_EN
  assign w_shift_en = (r_state == SH_SHIFT) && !pe_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = pe_stall;
  assign w_shift_en     = (r_state == SH_SHIFT);
`endif

  // SHIFT is only entered with a non-zero length, so len-1 never underflows here.
  assign w_last_shift = w_shift_en && (r_pos == (r_len - LEN_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SH_IDLE;
      r_len   <= '0;
      r_pos   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_len <= sc_len;
        r_pos <= '0;
      end else if (w_shift_en) begin
        r_pos <= r_pos + LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SH_IDLE:  if (sc_fire) w_state_nxt = SH_KICK;
      SH_KICK:  w_state_nxt = (r_len == '0) ? SH_DONE : SH_SHIFT;
      SH_SHIFT: if (w_last_shift) w_state_nxt = SH_DONE;
      SH_DONE:  w_state_nxt = SH_IDLE;
      default:  w_state_nxt = SH_IDLE;
    endcase
  end

  assign sc_ready    = (r_state == SH_IDLE);
  assign sh_kick     = (r_state == SH_KICK);
  assign sh_shift_en = w_shift_en;
  assign sh_done     = (r_state == SH_DONE);
  assign sh_pos      = r_pos;

endmodule

`default_nettype wire
